conv_scan_ctrl: RTL and testbench

CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

---
 rtl/conv_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_conv_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: serpentine frame-scan controller feeding an N-wide window shift register.
// Issues pixel reads (even rows left-to-right, odd rows right-to-left), tracks outstanding
// reads, steers returning data into the shift register and flags full windows.
// Build macro CONV_SCAN_PAUSE_EN adds a pause input that stalls read issue.
module conv_scan_ctrl #(
    parameter int N       = 11,
    parameter int W       = 64,
    parameter int H       = 64,
    parameter int AW      = 12,
    parameter int MAX_OUT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
`ifdef CONV_SCAN_PAUSE_EN
    input  logic                                  pause,
`endif
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rd_req,
    output logic [AW-1:0]                         rd_addr,
    input  logic                                  rd_gnt,
    input  logic                                  rd_dvalid,
    output logic                                  up_en,
    output logic                                  down_en,
    output logic                                  win_valid,
    output logic [$clog2(W)-1:0]                  win_x,
    output logic [((H > 1) ? $clog2(H) : 1)-1:0]  win_y
);

    localparam int XW   = $clog2(W);
    localparam int YW   = (H > 1) ? $clog2(H) : 1;
    localparam int CW   = $clog2(W + 1);
    localparam int HALF = (N - 1) / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] icnt;     // pixels issued so far in the issue row
    logic [YW-1:0] iy;       // issue row
    logic [CW-1:0] rcnt;     // pixels received so far in the receive row
    logic [YW-1:0] ry;       // receive row
    logic [3:0]    outst;    // reads granted but not yet returned

    logic          pause_i;
    logic          active;
    logic          grant;
    logic          dval;
    logic          issue_row_end;
    logic          issue_last;
    logic [CW-1:0] k_next;
    logic          rcv_row_end;
    logic          rcv_last;

`ifdef CONV_SCAN_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign active        = (state != IDLE);
    assign grant         = rd_req & rd_gnt;
    assign dval          = rd_dvalid & active;
    assign issue_row_end = (icnt == CW'(W - 1));
    assign issue_last    = issue_row_end && (iy == YW'(H - 1));
    assign k_next        = rcnt + 1'b1;
    assign rcv_row_end   = (k_next == CW'(W));
    assign rcv_last      = rcv_row_end && (ry == YW'(H - 1));

    // Request and shift steering are combinational so a full outstanding window or a
    // returning pixel takes effect in the same cycle.
    always_comb begin
        rd_req  = (state == RUN) && (outst < 4'(MAX_OUT)) && !pause_i;
        up_en   = dval & ~ry[0];
        down_en = dval &  ry[0];
    end

    // Frame sequencing: read issue walk, outstanding count, receive walk and window flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            rd_addr   <= '0;
            icnt      <= '0;
            iy        <= '0;
            rcnt      <= '0;
            ry        <= '0;
            outst     <= '0;
        end else begin
            done      <= 1'b0;
            win_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        state   <= RUN;
                        rd_addr <= '0;
                        icnt    <= '0;
                        iy      <= '0;
                        rcnt    <= '0;
                        ry      <= '0;
                        outst   <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (grant && !dval) begin
                        outst <= outst + 1'b1;
                    end else if (dval && !grant) begin
                        outst <= outst - 1'b1;
                    end

                    // Row turn-around is always +W: the serpentine lands directly below
                    // the last pixel of the row just finished.
                    if (grant) begin
                        if (issue_last) begin
                            state <= DRAIN;
                        end else if (issue_row_end) begin
                            icnt    <= '0;
                            iy      <= iy + 1'b1;
                            rd_addr <= rd_addr + AW'(W);
                        end else begin
                            icnt    <= icnt + 1'b1;
                            rd_addr <= iy[0] ? (rd_addr - 1'b1) : (rd_addr + 1'b1);
                        end
                    end

                    // Window centre is computed modulo 2^XW; the true value always fits.
                    if (dval) begin
                        win_valid <= (k_next >= CW'(N));
                        win_y     <= ry;
                        win_x     <= ry[0] ? (XW'(W + HALF) - XW'(k_next))
                                           : (XW'(k_next) - XW'(HALF + 1));
                        if (rcv_row_end) begin
                            rcnt <= '0;
                            ry   <= ry + 1'b1;
                        end else begin
                            rcnt <= k_next;
                        end
                        if (rcv_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: directed bench for conv_scan_ctrl with N=3, W=4, H=2, MAX_OUT=2.
// An in-order read responder with programmable latency answers every grant.
module tb_conv_scan_ctrl;

    localparam int N       = 3;
    localparam int W       = 4;
    localparam int H       = 2;
    localparam int AW      = 4;
    localparam int MAX_OUT = 2;

    localparam int EXP_ADDR [8] = '{0, 1, 2, 3, 7, 6, 5, 4};
    localparam int EXP_WX   [4] = '{1, 2, 2, 1};
    localparam int EXP_WY   [4] = '{0, 0, 1, 1};

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_dvalid;
    logic          up_en;
    logic          down_en;
    logic          win_valid;
    logic [1:0]    win_x;
    logic [0:0]    win_y;
`ifdef CONV_SCAN_PAUSE_EN
    logic          pause;
    int            pause_gnt;
    int            pause_up;
`endif

    int checks;
    int errors;
    int cyc;
    int lat;
    logic gnt_en;

    int pend_due [$];
    int addr_log [$];
    int wx_log   [$];
    int wy_log   [$];
    int rcv_n;
    int outst;
    int max_outst;
    int req_at_max;
    int dir_bad;
    int excl_bad;
    int hold_bad;
    int hold_cycles;
    int held_valid;
    int held_addr;
    int done_cnt;
    int busy_at_done;

    conv_scan_ctrl #(
        .N       (N),
        .W       (W),
        .H       (H),
        .AW      (AW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef CONV_SCAN_PAUSE_EN
        .pause     (pause),
`endif
        .busy      (busy),
        .done      (done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_dvalid (rd_dvalid),
        .up_en     (up_en),
        .down_en   (down_en),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pend_due.delete();
        addr_log.delete();
        wx_log.delete();
        wy_log.delete();
        rcv_n        = 0;
        outst        = 0;
        max_outst    = 0;
        req_at_max   = 0;
        dir_bad      = 0;
        excl_bad     = 0;
        hold_bad     = 0;
        hold_cycles  = 0;
        held_valid   = 0;
        held_addr    = 0;
        done_cnt     = 0;
        busy_at_done = 0;
    endtask

    // One clock cycle: drive responder inputs at the falling edge, observe, then advance.
    task automatic cycle();
        logic exp_up;
        logic g;
        @(negedge clk);
        rd_dvalid = (pend_due.size() > 0) && (pend_due[0] <= cyc);
        if (rd_dvalid) void'(pend_due.pop_front());
        rd_gnt = gnt_en;
        #1;
        g = rd_req && rd_gnt;
        if (rd_req && (outst >= MAX_OUT)) req_at_max++;
        if (rd_dvalid) begin
            exp_up = (((rcv_n / W) % 2) == 0);
            if ((up_en !== exp_up) || (down_en !== !exp_up)) dir_bad++;
            rcv_n++;
        end else if (up_en || down_en) begin
            dir_bad++;
        end
        if (up_en && down_en) excl_bad++;
        if (held_valid != 0 && rd_req && (int'(rd_addr) != held_addr)) hold_bad++;
        held_valid = (rd_req && !rd_gnt) ? 1 : 0;
        held_addr  = int'(rd_addr);
        if (rd_req && !rd_gnt) hold_cycles++;
        if (g) begin
            addr_log.push_back(int'(rd_addr));
            pend_due.push_back(cyc + lat);
        end
        outst = outst + (g ? 1 : 0) - (rd_dvalid ? 1 : 0);
        if (outst > max_outst) max_outst = outst;
        if (win_valid) begin
            wx_log.push_back(int'(win_x));
            wy_log.push_back(int'(win_y));
        end
        if (done) begin
            done_cnt++;
            busy_at_done = int'(busy);
        end
`ifdef CONV_SCAN_PAUSE_EN
        if (pause) begin
            if (g) pause_gnt++;
            if (up_en) pause_up++;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            cycle();
            n++;
        end
        check({tag, "_done_in_time"}, (n < 300) ? 1 : 0, 1);
    endtask

    task automatic check_addr_seq(input string tag);
        check({tag, "_addr_count"}, addr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (i < addr_log.size()) ? addr_log[i] : -1, EXP_ADDR[i]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        lat       = 1;
        gnt_en    = 1'b1;
        rst       = 1'b1;
        start     = 1'b0;
        rd_gnt    = 1'b0;
        rd_dvalid = 1'b0;
`ifdef CONV_SCAN_PAUSE_EN
        pause     = 1'b0;
        pause_gnt = 0;
        pause_up  = 0;
`endif
        clear_logs();

        // Reset state
        cycle();
        cycle();
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_rd_req",    int'(rd_req),    0);
        check("rst_rd_addr",   int'(rd_addr),   0);
        check("rst_win_valid", int'(win_valid), 0);
        check("rst_win_xy",    int'({win_x, win_y}), 0);
        rst = 1'b0;
        cycle();

        // Basic frame: grant always, one-cycle latency
        clear_logs();
        pulse_start();
        check("a_busy_after_start", int'(busy), 1);
        run_until_done("a");
        check_addr_seq("a");
        check("a_win_count", wx_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_win%0d_x", i), (i < wx_log.size()) ? wx_log[i] : -1, EXP_WX[i]);
            check($sformatf("a_win%0d_y", i), (i < wy_log.size()) ? wy_log[i] : -1, EXP_WY[i]);
        end
        check("a_busy_at_done", busy_at_done, 1);
        check("a_busy_after_done", int'(busy), 0);
        check("a_done_one_cycle", int'(done), 0);
        cycle();
        cycle();
        check("a_done_count", done_cnt, 1);
        check("a_dir_errors", dir_bad, 0);
        check("a_up_down_overlap", excl_bad, 0);

        // Grant withheld for 5 cycles mid-row
        clear_logs();
        pulse_start();
        cycle();
        cycle();
        gnt_en = 1'b0;
        repeat (5) cycle();
        gnt_en = 1'b1;
        run_until_done("b");
        check("b_stall_cycles", hold_cycles, 5);
        check("b_addr_held", hold_bad, 0);
        check_addr_seq("b");
        check("b_dir_errors", dir_bad, 0);

        // Long latency against MAX_OUT=2
        clear_logs();
        lat = 6;
        pulse_start();
        run_until_done("c");
        check("c_max_outstanding", max_outst, 2);
        check("c_req_while_full", req_at_max, 0);
        check_addr_seq("c");
        check("c_win_count", wx_log.size(), 4);
        lat = 1;

        // Start during busy is ignored; a later start rescans from 0
        clear_logs();
        pulse_start();
        cycle();
        cycle();
        pulse_start();
        run_until_done("d1");
        repeat (3) cycle();
        check("d1_busy_idle", int'(busy), 0);
        check("d1_done_count", done_cnt, 1);
        check_addr_seq("d1");
        clear_logs();
        pulse_start();
        run_until_done("d2");
        check_addr_seq("d2");

        // Reset after 5 grants
        clear_logs();
        pulse_start();
        for (int n = 0; n < 20 && addr_log.size() < 5; n++) cycle();
        check("e_grants_before_rst", addr_log.size(), 5);
        rst       = 1'b1;
        rd_dvalid = 1'b1;
        #1;
        check("e_busy",      int'(busy),      0);
        check("e_done",      int'(done),      0);
        check("e_rd_req",    int'(rd_req),    0);
        check("e_rd_addr",   int'(rd_addr),   0);
        check("e_win_valid", int'(win_valid), 0);
        check("e_up_down",   int'({up_en, down_en}), 0);
        check("e_win_x",     int'(win_x),     0);
        check("e_win_y",     int'(win_y),     0);
        rd_dvalid = 1'b0;
        clear_logs();
        cycle();
        rst = 1'b0;
        cycle();
        pulse_start();
        run_until_done("e");
        check_addr_seq("e");

`ifdef CONV_SCAN_PAUSE_EN
        // Pause stalls issue but returning data is still consumed
        clear_logs();
        lat = 3;
        pulse_start();
        cycle();
        cycle();
        pause = 1'b1;
        repeat (4) cycle();
        pause = 1'b0;
        run_until_done("p");
        check("p_grants_in_pause", pause_gnt, 0);
        check("p_up_in_pause", pause_up, 2);
        check_addr_seq("p");
        lat = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
